// File: rtl/servo_pwm_multi.sv
// ---------------------------------------------------------------------------
// servo_pwm_multi
//
// Multi-channel RC-servo pulse generator. All channels share one frame of
// PERIOD_US microseconds. Each channel owns a target width, clamped to
// [MIN_US, MAX_US] when written, and a current width. The current width moves
// toward the target by at most STEP_US per frame, and only at the frame
// boundary, so every emitted pulse is a whole, clean pulse.
//
// Ports:
//   clk          system clock (CLK_HZ, integer multiple of 1 MHz)
//   reset_n      asynchronous active-low reset
//   wr_en        one-cycle write strobe
//   wr_ch        channel index for the write
//   wr_pulse     requested pulse width in us (clamped before storing)
//   ch_en        per-channel output enable
//   servo        registered PWM outputs
//   at_target    per channel, current width equals target width
//   frame_start  one-cycle pulse in the first cycle of every frame
//   wr_err       one-cycle pulse after a write to a channel >= CH
// ---------------------------------------------------------------------------
module servo_pwm_multi #(
    parameter int CLK_HZ    = 125_000_000,
    parameter int CH        = 4,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int CENTER_US = 1500,
    parameter int STEP_US   = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [3:0]    wr_ch,
    input  logic [11:0]   wr_pulse,
    input  logic [CH-1:0] ch_en,
    output logic [CH-1:0] servo,
    output logic [CH-1:0] at_target,
    output logic          frame_start,
    output logic          wr_err
);

    localparam int DIV = CLK_HZ / 1_000_000;
    // A divide-by-one prescaler still needs a one-bit register.
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [14:0]   FRAME_MAX = 15'(PERIOD_US - 1);
    localparam logic [11:0]   MIN_W     = 12'(MIN_US);
    localparam logic [11:0]   MAX_W     = 12'(MAX_US);
    localparam logic [11:0]   CENTER_W  = 12'(CENTER_US);
    localparam logic [11:0]   STEP_W    = 12'(STEP_US);
    localparam logic [4:0]    CH_W      = 5'(CH);

    logic [PW-1:0] presc;
    logic          tick_us;
    logic [14:0]   frame_cnt;
    logic          boundary;
    logic          wr_valid;
    logic [11:0]   wr_clamped;
    logic [11:0]   target [CH];
    logic [11:0]   cur    [CH];

    assign tick_us  = (presc == PRESC_MAX);
    // The last microsecond of the frame: frame_cnt wraps on this edge.
    assign boundary = tick_us && (frame_cnt == FRAME_MAX);
    assign wr_valid = wr_en && ({1'b0, wr_ch} < CH_W);

    // NOTE: every always_comb output gets a default assignment first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_clamped = wr_pulse;
        if (wr_pulse < MIN_W) begin
            wr_clamped = MIN_W;
        end else if (wr_pulse > MAX_W) begin
            wr_clamped = MAX_W;
        end
    end

    always_comb begin
        at_target = '0;
        for (int i = 0; i < CH; i++) begin
            at_target[i] = (cur[i] == target[i]);
        end
    end

    // One ramp step from c toward t; differences in 13 bits cannot wrap.
    function automatic logic [11:0] ramp_step(input logic [11:0] c,
                                              input logic [11:0] t);
        logic [12:0] diff;
        logic [11:0] next;
        diff = '0;
        next = c;
        if (STEP_US == 0) begin
            next = t;
        end else if (c < t) begin
            diff = {1'b0, t} - {1'b0, c};
            next = (diff > {1'b0, STEP_W}) ? c + STEP_W : t;
        end else if (c > t) begin
            diff = {1'b0, c} - {1'b0, t};
            next = (diff > {1'b0, STEP_W}) ? c - STEP_W : t;
        end
        return next;
    endfunction

    // Timebase, frame counter and registered outputs.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
            servo       <= '0;
        end else begin
            presc <= tick_us ? '0 : presc + PW'(1);
            if (tick_us) begin
                frame_cnt <= (frame_cnt == FRAME_MAX) ? 15'd0 : frame_cnt + 15'd1;
            end
            frame_start <= boundary;
            wr_err      <= wr_en && !wr_valid;
            for (int i = 0; i < CH; i++) begin
                servo[i] <= ch_en[i] && (frame_cnt < {3'b000, cur[i]});
            end
        end
    end

    // Per-channel width registers. The ramp reads target before this edge,
    // so a write landing on the boundary only takes effect next frame.
    // NOTE: target/cur are small register arrays, not RAM, so they are reset
    // like any other flop to give a defined centre position after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                target[i] <= CENTER_W;
                cur[i]    <= CENTER_W;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (boundary) begin
                    cur[i] <= ramp_step(cur[i], target[i]);
                end
                if (wr_valid && (wr_ch == 4'(i))) begin
                    target[i] <= wr_clamped;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
`timescale 1ns/1ps
module tb_servo_pwm_multi;

    localparam int CLK_HZ    = 2_000_000;
    localparam int DIV       = CLK_HZ / 1_000_000;
    localparam int CH        = 4;
    localparam int PERIOD_US = 700;
    localparam int MIN_US    = 100;
    localparam int MAX_US    = 600;
    localparam int CENTER_US = 300;
    localparam int STEP_US   = 20;
    localparam int P         = PERIOD_US * DIV;   // clock cycles per frame

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [3:0]    wr_ch;
    logic [11:0]   wr_pulse;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] servo_a, att_a, servo_b, att_b;
    logic          fs_a, fs_b, err_a, err_b;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .CLK_HZ(CLK_HZ), .CH(CH), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .CENTER_US(CENTER_US), .STEP_US(STEP_US)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pulse(wr_pulse), .ch_en(ch_en), .servo(servo_a),
        .at_target(att_a), .frame_start(fs_a), .wr_err(err_a)
    );

    servo_pwm_multi #(
        .CLK_HZ(CLK_HZ), .CH(CH), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .CENTER_US(CENTER_US), .STEP_US(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pulse(wr_pulse), .ch_en(ch_en), .servo(servo_b),
        .at_target(att_b), .frame_start(fs_b), .wr_err(err_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected behaviour of one frame for both instances.
    typedef struct packed {
        logic                 last;
        logic [CH-1:0]        care;
        logic [CH-1:0]        exp_at_a;
        logic [CH-1:0]        exp_at_b;
        logic [CH-1:0][12:0]  wa;
        logic [CH-1:0][12:0]  wb;
    } frame_t;

    frame_t sb[$];

    // Reference model: widths in microseconds, updated once per frame.
    int            tgt_a[CH], cur_a[CH], tgt_b[CH], cur_b[CH];
    logic [CH-1:0] care_m;
    int            now;
    bit            mon_done = 1'b0;

    function automatic int clamp_us(input int v);
        if (v < MIN_US) return MIN_US;
        if (v > MAX_US) return MAX_US;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            tgt_a[i] = CENTER_US; cur_a[i] = CENTER_US;
            tgt_b[i] = CENTER_US; cur_b[i] = CENTER_US;
        end
    endtask

    task automatic model_write(input int ch, input int val);
        if (ch < CH) begin
            tgt_a[ch] = clamp_us(val);
            tgt_b[ch] = clamp_us(val);
        end
    endtask

    task automatic model_boundary();
        for (int i = 0; i < CH; i++) begin
            if (cur_a[i] < tgt_a[i])
                cur_a[i] += (tgt_a[i] - cur_a[i] < STEP_US) ? tgt_a[i] - cur_a[i] : STEP_US;
            else if (cur_a[i] > tgt_a[i])
                cur_a[i] -= (cur_a[i] - tgt_a[i] < STEP_US) ? cur_a[i] - tgt_a[i] : STEP_US;
            cur_b[i] = tgt_b[i];
        end
    endtask

    function automatic frame_t expect_frame(input bit last);
        frame_t f;
        f = '0;
        f.last = last;
        f.care = care_m;
        for (int i = 0; i < CH; i++) begin
            f.wa[i]       = ch_en[i] ? 13'(cur_a[i] * DIV) : 13'd0;
            f.wb[i]       = ch_en[i] ? 13'(cur_b[i] * DIV) : 13'd0;
            f.exp_at_a[i] = (cur_a[i] == tgt_a[i]);
            f.exp_at_b[i] = (cur_b[i] == tgt_b[i]);
        end
        return f;
    endfunction

    // 'now' counts rising edges since reset release; inputs change on negedges.
    task automatic tick();
        @(negedge clk);
        now++;
    endtask

    task automatic advance_to(input int t);
        while (now < t) tick();
    endtask

    task automatic mid_write(input int ch, input int val);
        wr_en = 1'b1; wr_ch = 4'(ch); wr_pulse = 12'(val);
        tick();
        wr_en = 1'b0;
        model_write(ch, val);
        check("wr_err_a", err_a, (ch >= CH));
        check("wr_err_b", err_b, (ch >= CH));
        if (ch >= CH) begin
            tick();
            check("wr_err_clear", err_a, 0);
        end
    endtask

    // Ends the frame with the boundary at edge n*P, optionally writing on
    // that very edge, and queues the expectation for the frame that follows.
    task automatic finish_frame(input int n, input bit bw, input int bch,
                                input int bval, input bit last);
        advance_to(n * P - 1);
        model_boundary();
        if (bw) begin
            wr_en = 1'b1; wr_ch = 4'(bch); wr_pulse = 12'(bval);
            model_write(bch, bval);
        end
        sb.push_back(expect_frame(last));
        tick();
        wr_en = 1'b0;
    endtask

    // Monitor: on every frame_start, measure each channel's high time.
    initial begin : monitor
        frame_t e;
        int     cnt_a[CH];
        int     cnt_b[CH];
        int     waited;
        forever begin
            waited = 0;
            while (fs_a !== 1'b1 && waited < 2 * P + 20) begin
                @(negedge clk);
                waited++;
            end
            if (fs_a !== 1'b1) begin
                check("frame_start_timeout", 0, 1);
                break;
            end
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 0, 1);
                break;
            end
            e = sb.pop_front();
            if (e.last) break;
            check("frame_start_b", fs_b, 1);
            for (int i = 0; i < CH; i++) begin
                cnt_a[i] = 0;
                cnt_b[i] = 0;
            end
            for (int k = 0; k < P; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    check("at_target_a", att_a, e.exp_at_a);
                    check("at_target_b", att_b, e.exp_at_b);
                end
                for (int i = 0; i < CH; i++) begin
                    cnt_a[i] += int'(servo_a[i]);
                    cnt_b[i] += int'(servo_b[i]);
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (e.care[i]) begin
                    check($sformatf("width_a ch%0d", i), cnt_a[i], e.wa[i]);
                    check($sformatf("width_b ch%0d", i), cnt_b[i], e.wb[i]);
                end
            end
            check("frame_period", fs_a, 1);
        end
        mon_done = 1'b1;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            off;
        int            nw;
        int            tval;
        int            cnt[CH];
        logic [CH-1:0] exp_hi;

        reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_pulse = '0; ch_en = '1;
        care_m = '1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset servo_a", servo_a, 0);
        check("reset at_target_a", att_a, {CH{1'b1}});
        check("reset frame_start", fs_a, 0);
        check("reset wr_err", err_a, 0);
        reset_n = 1'b1;
        now = 0;

        // Idle frames at the centre position.
        finish_frame(1, 0, 0, 0, 0);
        finish_frame(2, 0, 0, 0, 0);
        finish_frame(3, 0, 0, 0, 0);

        // ch1 ramp toward 400.
        advance_to(3 * P + 10);
        mid_write(1, 400);
        finish_frame(4, 0, 0, 0, 0);

        // Clamp at both ends.
        advance_to(4 * P + 20);
        mid_write(0, 50);
        advance_to(4 * P + 40);
        mid_write(2, 4000);
        finish_frame(5, 0, 0, 0, 0);

        // Write landing exactly on the boundary edge.
        finish_frame(6, 1, 3, 400, 0);

        // Out-of-range channel, then a valid write seen in full by the STEP 0 unit.
        advance_to(6 * P + 50);
        mid_write(CH, 555);
        advance_to(6 * P + 100);
        mid_write(1, 550);
        advance_to(7 * P - 20);
        ch_en[3] = 1'b0;
        finish_frame(7, 0, 0, 0, 0);

        advance_to(8 * P - 20);
        ch_en[3] = 1'b1;
        care_m[0] = 1'b0;
        finish_frame(8, 0, 0, 0, 0);

        // Drop ch_en[0] in the middle of its pulse.
        advance_to(8 * P + 100);
        check("ch0 high before drop a", servo_a[0], (100 <= cur_a[0] * DIV));
        check("ch0 high before drop b", servo_b[0], (100 <= cur_b[0] * DIV));
        ch_en[0] = 1'b0;
        tick();
        check("ch0 low after drop a", servo_a[0], 0);
        check("ch0 low after drop b", servo_b[0], 0);
        advance_to(9 * P - 40);
        ch_en[0] = 1'b1;
        care_m = '1;
        finish_frame(9, 0, 0, 0, 0);

        // Let the long ch2 ramp run out.
        for (int n = 10; n <= 20; n++) finish_frame(n, 0, 0, 0, 0);

        // Randomised writes, including boundary-edge writes.
        for (int n = 21; n <= 30; n++) begin
            off = 0;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                off += int'($urandom_range(5, 300));
                if (off > P - 30) break;
                advance_to((n - 1) * P + off);
                mid_write(int'($urandom_range(0, CH)), int'($urandom_range(0, 4095)));
            end
            if ($urandom_range(0, 2) == 0)
                finish_frame(n, 1, int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 4095)), 0);
            else
                finish_frame(n, 0, 0, 0, 0);
        end
        finish_frame(31, 0, 0, 0, 1);
        for (int k = 0; k < 20 && !mon_done; k++) tick();
        check("monitor_done", mon_done, 1);

        // Start a ramp, then reset in the middle of it.
        tval = (cur_a[1] > 350) ? 100 : 600;
        advance_to(31 * P + 10);
        mid_write(1, tval);
        advance_to(32 * P + 5);
        model_boundary();
        check("mid-ramp at_target_a[1]", att_a[1], (cur_a[1] == tgt_a[1]));
        check("mid-ramp at_target_b[1]", att_b[1], (cur_b[1] == tgt_b[1]));
        advance_to(32 * P + 50);
        for (int i = 0; i < CH; i++) exp_hi[i] = (50 <= cur_a[i] * DIV);
        check("servo_a before reset", servo_a, exp_hi);
        reset_n = 1'b0;
        #1;
        check("async reset servo_a", servo_a, 0);
        check("async reset servo_b", servo_b, 0);
        check("async reset at_target_a", att_a, {CH{1'b1}});
        check("async reset frame_start", fs_a, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        now = 0;
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        for (int k = 1; k <= P; k++) begin
            tick();
            if (k == 1) check("post-reset at_target_a", att_a, {CH{1'b1}});
            for (int i = 0; i < CH; i++) cnt[i] += int'(servo_a[i]);
        end
        check("post-reset frame_start", fs_a, 1);
        for (int i = 0; i < CH; i++)
            check($sformatf("post-reset width ch%0d", i), cnt[i], CENTER_US * DIV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Multi-channel RC-servo pulse generator: one fixed-period frame (50 Hz by default) shared by CH channels; each channel has a programmable pulse width in microseconds.
- Per-channel target written over a simple write port, clamped to a safe range, then slew-limited toward the output at frame boundaries.
- Generalises the single-channel fixed-duty servo driver: channel count, frame period, pulse limits and ramp rate are parameters; adds glitch-free updates, per-channel enable and at-target status.
- Sits between a control source (button/mode FSM, sweep logic, CPU register) and the servo pins.

Parameters:
- CLK_HZ, 125000000, system clock frequency; must be an integer multiple of 1 MHz.
- CH, 4, number of servo channels (1..16).
- PERIOD_US, 20000, frame period in us (max 32767).
- MIN_US, 500, lower clamp for pulse width in us.
- MAX_US, 2500, upper clamp for pulse width in us (max 4095, < PERIOD_US).
- CENTER_US, 1500, reset value of target and current width.
- STEP_US, 20, maximum change of current width per frame; 0 = jump straight to target.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, one cycle
- wr_ch  in  4  channel index for write
- wr_pulse  in  12  requested pulse width, us
- ch_en  in  CH  per-channel output enable
- servo  out  CH  PWM outputs, registered
- at_target  out  CH  current width == target width, per channel
- frame_start  out  1  one-cycle pulse when frame counter wraps to 0
- wr_err  out  1  one-cycle pulse on write with wr_ch >= CH

Behaviour:
- Reset (async assert, sync release on clk): prescaler=0, frame_cnt=0, target[i]=cur[i]=CENTER_US, servo=0, frame_start=0, wr_err=0, at_target=all 1.
- Prescaler: counts 0..CLK_HZ/1e6-1. tick_us is high for one cycle when the prescaler wraps.
- frame_cnt (15 bit): increments on tick_us and wraps PERIOD_US-1 -> 0. The wrap cycle is the frame boundary.
- frame_start is registered and asserted the cycle after the boundary: exactly one pulse per PERIOD_US us.
- Output: servo[i] <= ch_en[i] && (frame_cnt < cur[i]), registered, so 1-cycle latency from frame_cnt.
  - High time is cur[i] us, rising at frame start.
  - Deasserting ch_en forces low on the next cycle. Reasserting resumes mid-frame with the compare as-is; no partial-pulse suppression.
- Write: on wr_en with wr_ch < CH, target[wr_ch] <= clamp(wr_pulse, MIN_US, MAX_US) on the next edge.
  - wr_ch >= CH: no state change, and wr_err pulses for one cycle.
  - Back-to-back writes are allowed; the last write wins.
- Ramp: only at the frame boundary, for each i:
  - if cur < target: cur <= cur + min(STEP_US, target - cur);
  - if cur > target: cur <= cur - min(STEP_US, cur - target);
  - STEP_US=0: cur <= target.
  - cur never changes mid-frame, so no runt or extended pulses.
- Write in the same cycle as the boundary: the ramp uses the pre-write target; the new target is applied from the following frame.
- at_target[i] = (cur[i] == target[i]), combinational from registers.
- Arithmetic: 12-bit unsigned widths; differences are computed in 13 bits, so no wrap-around.
- A mid-operation reset returns every channel to CENTER_US immediately, with outputs low.

Test Plan:
- Reset then idle 3 frames (CLK_HZ=1e6 sim setting, PERIOD_US=20000) -> every enabled servo high 1500 us from each frame start; frame_start every 20000 cycles; at_target=all 1.
- Write ch1=1600, STEP_US=20 -> ch1 high widths 1500 in the current frame, then 1520, 1540, 1560, 1580, 1600 in successive frames; at_target[1] low until the 1600 frame; other channels unchanged.
- Write ch0=100 and ch2=4000 -> targets clamp to 500 and 2500; ch2 reaches 2500 after 50 frames at STEP 20.
- Write ch3=1700 in the exact frame-boundary cycle -> ch3 still 1500 in the next frame, 1520 in the one after.
- Write wr_ch=CH -> wr_err one-cycle pulse; no target changes; with STEP_US=0, a valid write of 2000 appears in full in the next frame.
- Drop ch_en[0] mid-pulse -> servo[0] low next cycle; assert reset_n=0 mid-ramp -> all outputs 0 immediately, widths 1500 after release.
